// File: rtl/guess_sequencer.sv
// Two-player number-guessing game controller: keypad conditioning, arbitration,
// secret/guess storage and the SET -> GUESS -> CHECK -> WIN/LOSE sequencing.
module guess_sequencer #(
    parameter int MAX_LEN   = 7,
    parameter int MIN_LEN   = 4,
    parameter int MAX_TURNS = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           I1,
    input  logic                           I2,
    input  logic                           I3,
    input  logic                           I4,
    input  logic                           enter,
    output logic [2:0]                     phase,
    output logic [$clog2(MAX_LEN+1)-1:0]   numa,
    output logic [$clog2(MAX_LEN+1)-1:0]   numb,
    output logic [$clog2(MAX_TURNS+1)-1:0] turn,
    output logic                           sym_wr,
    output logic                           sym_who,
    output logic [1:0]                     sym,
    output logic [$clog2(MAX_LEN)-1:0]     sym_pos,
    output logic                           win,
    output logic                           lose,
    output logic                           equal,
    output logic                           bigger,
    output logic                           smaller
);
    localparam int NW = $clog2(MAX_LEN + 1);
    localparam int PW = $clog2(MAX_LEN);
    localparam int TW = $clog2(MAX_TURNS + 1);
    localparam logic [NW-1:0] MAX_N = NW'(MAX_LEN);
    localparam logic [NW-1:0] MIN_N = NW'(MIN_LEN);
    localparam logic [TW-1:0] MAX_T = TW'(MAX_TURNS);

    typedef enum logic [2:0] {
        SET_A   = 3'd0,
        GUESS_B = 3'd1,
        CHECK   = 3'd2,
        WIN     = 3'd3,
        LOSE    = 3'd4
    } state_t;

    state_t      state;
    logic [4:0]  raw;
    logic [4:0]  sync1;
    logic [4:0]  sync2;
    logic [4:0]  prev;
    logic [1:0]  warm;
    logic [4:0]  pulse;
    logic [3:0]  key_pulse;
    logic        ent_pulse;
    logic        key_hit;
    logic [1:0]  key_code;
    logic [1:0]  secret [MAX_LEN];
    logic [1:0]  guess  [MAX_LEN];
    logic [NW-1:0] na_eff;
    logic [NW-1:0] nb_eff;
    logic          b_store;
    logic [PW-1:0] pos_a;
    logic [PW-1:0] pos_b;
    logic [TW-1:0] turn_plus;
    logic          match;

    assign raw   = {enter, I4, I3, I2, I1};
    assign phase = state;

    // The edge detector is held "high" for two cycles after reset release, so a
    // button that was already down when reset lifted never yields a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '1;
            warm  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (warm != 2'd2) begin
                warm <= warm + 2'd1;
                prev <= '1;
            end else begin
                prev <= sync2;
            end
        end
    end

    assign pulse     = sync2 & ~prev;
    assign key_pulse = pulse[3:0];
    assign ent_pulse = pulse[4];
    assign key_hit   = |key_pulse;

    always_comb begin
        key_code = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (key_pulse[i]) key_code = 2'(i);
        end
    end

    // Counts as they will be after this cycle's key (if any) is stored.
    assign na_eff    = key_hit ? numa + NW'(1) : numa;
    assign b_store   = key_hit && (numb != MAX_N);
    assign nb_eff    = b_store ? numb + NW'(1) : numb;
    assign pos_a     = PW'(numa);
    assign pos_b     = PW'(numb);
    assign turn_plus = turn + TW'(1);

    always_comb begin
        match = (numb == numa);
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(numa) && secret[i] != guess[i]) match = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SET_A;
            numa    <= '0;
            numb    <= '0;
            turn    <= '0;
            sym_wr  <= 1'b0;
            sym_who <= 1'b0;
            sym     <= '0;
            sym_pos <= '0;
            win     <= 1'b0;
            lose    <= 1'b0;
            equal   <= 1'b0;
            bigger  <= 1'b0;
            smaller <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                secret[i] <= '0;
                guess[i]  <= '0;
            end
        end else begin
            sym_wr <= 1'b0;
            case (state)
                SET_A: begin
                    if (key_hit) begin
                        secret[pos_a] <= key_code;
                        numa    <= na_eff;
                        sym_wr  <= 1'b1;
                        sym_who <= 1'b0;
                        sym     <= key_code;
                        sym_pos <= pos_a;
                    end
                    if (na_eff == MAX_N || (ent_pulse && na_eff >= MIN_N)) state <= GUESS_B;
                end
                GUESS_B: begin
                    if (b_store) begin
                        guess[pos_b] <= key_code;
                        numb    <= nb_eff;
                        sym_wr  <= 1'b1;
                        sym_who <= 1'b1;
                        sym     <= key_code;
                        sym_pos <= pos_b;
                    end
                    if (ent_pulse && nb_eff >= MIN_N) state <= CHECK;
                end
                CHECK: begin
                    equal   <= (numa == numb);
                    bigger  <= (numa > numb);
                    smaller <= (numa < numb);
                    if (match) begin
                        win   <= 1'b1;
                        state <= WIN;
                    end else begin
                        turn <= turn_plus;
                        if (turn_plus == MAX_T) begin
                            lose  <= 1'b1;
                            state <= LOSE;
                        end else begin
                            numb <= '0;
                            for (int i = 0; i < MAX_LEN; i++) guess[i] <= '0;
                            state <= GUESS_B;
                        end
                    end
                end
                WIN, LOSE: begin
                    if (ent_pulse) begin
                        state   <= SET_A;
                        numa    <= '0;
                        numb    <= '0;
                        turn    <= '0;
                        sym_who <= 1'b0;
                        sym     <= '0;
                        sym_pos <= '0;
                        win     <= 1'b0;
                        lose    <= 1'b0;
                        equal   <= 1'b0;
                        bigger  <= 1'b0;
                        smaller <= 1'b0;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            secret[i] <= '0;
                            guess[i]  <= '0;
                        end
                    end
                end
                default: state <= SET_A;
            endcase
        end
    end
endmodule

// File: tb/tb_guess_sequencer.sv
// Scoreboard bench for guess_sequencer: a game-level model queues expected symbol
// writes and phase transitions; a negedge monitor pops and compares them.
module tb_guess_sequencer;
    localparam int MAX_LEN   = 7;
    localparam int MIN_LEN   = 4;
    localparam int MAX_TURNS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, I4 = 1'b0, enter = 1'b0;
    logic [2:0] phase;
    logic [2:0] numa, numb;
    logic [1:0] turn;
    logic       sym_wr, sym_who;
    logic [1:0] sym;
    logic [2:0] sym_pos;
    logic       win, lose, equal, bigger, smaller;

    always #5 clk = ~clk;

    guess_sequencer #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .MAX_TURNS(MAX_TURNS)) dut (
        .clk(clk), .reset(reset),
        .I1(I1), .I2(I2), .I3(I3), .I4(I4), .enter(enter),
        .phase(phase), .numa(numa), .numb(numb), .turn(turn),
        .sym_wr(sym_wr), .sym_who(sym_who), .sym(sym), .sym_pos(sym_pos),
        .win(win), .lose(lose), .equal(equal), .bigger(bigger), .smaller(smaller)
    );

    typedef struct packed { int who; int code; int pos; int cnt; } sym_ev_t;
    typedef struct packed { int ph; int na; int nb; int tn; int w; int l; int eq; int bg; int sm; } ph_ev_t;

    sym_ev_t sym_q[$];
    ph_ev_t  ph_q[$];
    int total = 0;
    int bad   = 0;

    // Game-level reference model
    int m_phase = 0;
    int m_secret[$];
    int m_guess[$];
    int m_turn = 0, m_win = 0, m_lose = 0, m_eq = 0, m_bg = 0, m_sm = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_phase();
        ph_q.push_back('{m_phase, m_secret.size(), m_guess.size(), m_turn,
                         m_win, m_lose, m_eq, m_bg, m_sm});
    endtask

    function automatic bit same_seq();
        if (m_secret.size() != m_guess.size()) return 1'b0;
        for (int i = 0; i < m_secret.size(); i++)
            if (m_secret[i] != m_guess[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        m_secret.delete();
        m_guess.delete();
        m_turn = 0; m_win = 0; m_lose = 0; m_eq = 0; m_bg = 0; m_sm = 0;
    endtask

    task automatic model_step(input logic [3:0] mask, input logic ent);
        int key = -1;
        for (int i = 3; i >= 0; i--) if (mask[i]) key = i;
        case (m_phase)
            0: begin
                if (key >= 0) begin
                    m_secret.push_back(key);
                    sym_q.push_back('{0, key, m_secret.size() - 1, m_secret.size()});
                end
                if (m_secret.size() == MAX_LEN || (ent && m_secret.size() >= MIN_LEN)) begin
                    m_phase = 1;
                    push_phase();
                end
            end
            1: begin
                if (key >= 0 && m_guess.size() < MAX_LEN) begin
                    m_guess.push_back(key);
                    sym_q.push_back('{1, key, m_guess.size() - 1, m_guess.size()});
                end
                if (ent && m_guess.size() >= MIN_LEN) begin
                    m_phase = 2;
                    push_phase();
                    m_eq = (m_secret.size() == m_guess.size());
                    m_bg = (m_secret.size() > m_guess.size());
                    m_sm = (m_secret.size() < m_guess.size());
                    if (same_seq()) begin
                        m_win = 1;
                        m_phase = 3;
                    end else begin
                        m_turn++;
                        if (m_turn == MAX_TURNS) begin
                            m_lose = 1;
                            m_phase = 4;
                        end else begin
                            m_guess.delete();
                            m_phase = 1;
                        end
                    end
                    push_phase();
                end
            end
            default: begin
                if (ent) begin
                    model_clear();
                    m_phase = 0;
                    push_phase();
                end
            end
        endcase
    endtask

    // Monitor
    int      last_phase = 0;
    sym_ev_t mon_s;
    ph_ev_t  mon_p;
    always @(negedge clk) begin
        if (sym_wr) begin
            if (sym_q.size() == 0) begin
                chk("unexpected_sym_wr", int'(sym), -1);
            end else begin
                mon_s = sym_q.pop_front();
                chk("sym_who", int'(sym_who), mon_s.who);
                chk("sym", int'(sym), mon_s.code);
                chk("sym_pos", int'(sym_pos), mon_s.pos);
                chk("sym_count", sym_who ? int'(numb) : int'(numa), mon_s.cnt);
                $display("sym  who=%0d sym=%0d pos=%0d numa=%0d numb=%0d", sym_who, sym, sym_pos, numa, numb);
            end
        end
        if (int'(phase) != last_phase) begin
            if (ph_q.size() == 0) begin
                chk("unexpected_phase", int'(phase), last_phase);
            end else begin
                mon_p = ph_q.pop_front();
                chk("phase", int'(phase), mon_p.ph);
                chk("numa", int'(numa), mon_p.na);
                chk("numb", int'(numb), mon_p.nb);
                chk("turn", int'(turn), mon_p.tn);
                chk("win", int'(win), mon_p.w);
                chk("lose", int'(lose), mon_p.l);
                chk("equal", int'(equal), mon_p.eq);
                chk("bigger", int'(bigger), mon_p.bg);
                chk("smaller", int'(smaller), mon_p.sm);
                $display("phase %0d->%0d numa=%0d numb=%0d turn=%0d win=%0d lose=%0d eq/bg/sm=%0d%0d%0d",
                         last_phase, phase, numa, numb, turn, win, lose, equal, bigger, smaller);
            end
            last_phase = int'(phase);
        end
    end

    task automatic drive(input logic [3:0] mask, input logic ent);
        int hold = $urandom_range(1, 3);
        model_step(mask, ent);
        @(posedge clk); #1;
        {I4, I3, I2, I1} = mask;
        enter = ent;
        repeat (hold) @(posedge clk);
        #1;
        {I4, I3, I2, I1} = 4'b0000;
        enter = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic key(input int k);
        logic [3:0] m = 4'b0001;
        drive(m << k, 1'b0);
    endtask

    task automatic ent();
        drive(4'b0000, 1'b1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_phase"}, int'(phase), 0);
        chk({tag, "_numa"}, int'(numa), 0);
        chk({tag, "_numb"}, int'(numb), 0);
        chk({tag, "_turn"}, int'(turn), 0);
        chk({tag, "_sym"}, int'({sym_wr, sym_who, sym, sym_pos}), 0);
        chk({tag, "_result"}, int'({win, lose}), 0);
        chk({tag, "_hint"}, int'({equal, bigger, smaller}), 0);
    endtask

    // Reset asserted between edges; optionally a key is held through release.
    task automatic mid_reset(input logic [3:0] held);
        @(posedge clk); #3;
        model_clear();
        if (m_phase != 0) begin
            m_phase = 0;
            push_phase();
        end
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        {I4, I3, I2, I1} = held;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1 {I4, I3, I2, I1} = 4'b0000;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        bad++;
        $display("FAIL watchdog: cycle budget expired, got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2 reset = 1'b0;
        #1 chk_zero("init_reset");
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        repeat (5) @(posedge clk);

        // Set and immediate win, then restart
        for (int k = 0; k < 4; k++) key(k);
        ent();
        for (int k = 0; k < 4; k++) key(k);
        ent();
        ent();

        // Short enter ignored; fourth key together with enter advances
        key(0); key(1); key(2);
        ent();
        drive(4'b1000, 1'b1);
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < 4; k++) key(1);
            ent();
        end
        ent();

        // Length hints: longer secret, then longer guess, then a win
        key(0); key(1); key(2); key(3); key(0); ent();
        key(0); key(1); key(2); key(3); ent();
        key(0); key(1); key(2); key(3); key(0); key(1); ent();
        key(0); key(1); key(2); key(3); key(0); ent();
        ent();

        // Simultaneous press, auto-advance, guess saturation, reset mid-guess
        drive(4'b1010, 1'b0);
        for (int k = 0; k < 6; k++) key(k % 4);
        for (int k = 0; k < 8; k++) key(2);
        ent();
        key(3); key(0);
        mid_reset(4'b0100);
        key(0);

        // Randomized play
        for (int n = 0; n < 400; n++) begin
            logic [3:0] mask;
            logic       e;
            int         r = $urandom_range(0, 9);
            if (m_phase == 1 && m_guess.size() == 0 && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < m_secret.size(); i++) key(m_secret[i]);
                ent();
            end
            if (r < 6) mask = 4'b0001 << $urandom_range(0, 3);
            else if (r < 8) mask = 4'($urandom_range(1, 15));
            else mask = 4'b0000;
            e = (mask == 4'b0000) || ($urandom_range(0, 3) == 0);
            drive(mask, e);
        end

        repeat (10) @(posedge clk);
        chk("sym_queue_drained", sym_q.size(), 0);
        chk("phase_queue_drained", ph_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/guess_sequencer.md
# guess_sequencer

Clocked game controller for the two-player number-guessing game. It arbitrates the shared four-button keypad between the setter (player A) and the guesser (player B), and stores the secret and guess symbol sequences. It sequences the SET → GUESS → CHECK phases, counts turns, and produces the win/lose and length-hint flags that drive the display. It replaces edge-triggered button handling with a single synchronous state machine.

## Interface
- `MAX_LEN`, 7: maximum symbols per sequence.
- `MIN_LEN`, 4: minimum symbols before `enter` is accepted.
- `MAX_TURNS`, 3: guesses allowed before lose.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `I1`..`I4` in 1 each: raw keypad buttons, asynchronous, level-high when pressed.
- `enter` in 1: raw enter button, asynchronous.
- `phase` out 3: current state code. SET_A=0, GUESS_B=1, CHECK=2, WIN=3, LOSE=4.
- `numa` out clog2(MAX_LEN+1): symbols stored in the secret.
- `numb` out clog2(MAX_LEN+1): symbols stored in the current guess.
- `turn` out clog2(MAX_TURNS+1): completed non-winning guesses.
- `sym_wr` out 1: one-cycle pulse when a symbol is stored.
- `sym_who` out 1: owner of the stored symbol, 0=A, 1=B.
- `sym` out 2: symbol code of the stored symbol. I1=0, I2=1, I3=2, I4=3.
- `sym_pos` out clog2(MAX_LEN): position written.
- `win`, `lose` out 1 each: game result, sticky until restart.
- `equal`, `bigger`, `smaller` out 1 each: length hint from the last check. `bigger` means the secret is longer than the guess.

## Operation
- **Input conditioning:** each of the five buttons passes through a 2-flop synchronizer, then a rising-edge detector, producing a one-cycle press pulse. Holding a button produces exactly one pulse.
- **Arbitration:** if several key pulses occur in the same cycle, the lowest index wins (I1 > I2 > I3 > I4) and the others are dropped. A key pulse and an enter pulse in the same cycle: the key is processed first; enter is evaluated against the updated count in the same cycle.
- **SET_A:**
  - A key pulse stores the symbol at `secret[numa]`, increments `numa`, and pulses `sym_wr` with `sym_who=0`.
  - Enter with `numa >= MIN_LEN` goes to GUESS_B. Enter below `MIN_LEN` is ignored.
  - `numa` reaching `MAX_LEN` goes to GUESS_B automatically.
- **GUESS_B:**
  - A key pulse stores into `guess[numb]`, with `sym_who=1`.
  - Key pulses are ignored once `numb == MAX_LEN`; there is no auto-advance.
  - Enter with `numb >= MIN_LEN` goes to CHECK.
- **CHECK:** lasts one cycle and evaluates the guess.
  - match = (`numb == numa`) AND all positions below `numa` are equal.
  - `equal`/`bigger`/`smaller` are updated from the `numa` vs `numb` compare; exactly one is set.
  - On match: `win`=1, go to WIN.
  - Otherwise `turn` increments. If the new `turn == MAX_TURNS`: `lose`=1, go to LOSE. Else clear `numb` and the guess store, return to GUESS_B.
- **WIN / LOSE:** keys are ignored. An enter pulse restarts the game: everything is cleared except the hint flags, which are cleared too, and the state returns to SET_A.
- **Counter arithmetic:** counters never wrap; `numa`/`numb` saturate at `MAX_LEN`.

## Timing
- **Reset values:** reset low clears everything immediately. `phase`=SET_A; `numa`, `numb`, `turn`, `sym`, `sym_pos`, `sym_who`, `sym_wr`, `win`, `lose`, `equal`, `bigger`, `smaller` = 0; synchronizer flops = 0.
- **Reset mid-operation:** abandons the game, with no partial writes. A button held high through reset release is treated as a fresh press only if its synchronizer sees 0→1, so a held button produces no press.
- **Key latency:** a button rising before clk edge k produces `sym_wr` high in the cycle after edge k+2. `numa`/`numb` update on that same edge.
- **Phase change:** takes effect on the same edge as the triggering enter pulse.
- **CHECK timing:** CHECK occupies exactly one cycle. The flags and `turn` update on the edge leaving CHECK.
- **Held buttons during CHECK:** a key pulse arriving while in CHECK is dropped.

## Test plan
- **Set and immediate win:** press I1, I2, I3, I4, enter as A, then the same as B, then enter. Expect `phase` 0→1→2→3, `numa`=`numb`=4, `win`=1, `equal`=1, `turn`=0.
- **Short enter ignored:** A presses I1, I2, I3, enter. Expect `phase` stays 0 and `numa`=3. A fourth key and enter then move to phase 1.
- **Three misses:** with secret 0,1,2,3, B enters 1,1,1,1 three times. Expect `turn` 1, 2, then `lose`=1, `phase`=4, `win`=0, and `numb` cleared to 0 between guesses.
- **Length hints:** secret of 5 symbols, guess of 4. Expect `bigger`=1. Then a guess of 6 gives `smaller`=1; exactly one hint bit is set each time.
- **Simultaneous press and saturation:** I2 and I4 rise on the same cycle. Expect one `sym_wr` with `sym`=1. Seven A presses auto-advance to phase 1 with `numa`=7.
- **Reset and restart:** drop `reset` mid-GUESS_B. Expect all outputs 0 and `phase`=0 asynchronously. Separately, an enter in WIN gives `phase`=0 and `win`=0.
